cpu_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 15-bit-PC CPU.
- Owns the PC register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Shares the single-port memory between instruction fetch and data access with a req/ack handshake.
- Consumes class flags and jump/branch target from control_unit; replaces the free-running PC_incr loop.

---
 rtl/cpu_seq_pkg.sv | 17 +
 rtl/seq_pc_next.sv | 13 +
 rtl/cpu_sequencer.sv | 108 ++++++++++
 tb/tb_cpu_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared widths, reset PC and state/next-PC encodings for the sequencer
package cpu_seq_pkg;
  localparam int PC_W = 15;
  localparam int INSTR_W = 32;
  localparam int CNT_W = 16;
  localparam logic [14:0] RESET_PC = 15'd0;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_TGT} pc_sel_t;
endpackage

// File: rtl/seq_pc_next.sv
// seq_pc_next: combinational next-PC select (hold / +1 wrapping / target)
module seq_pc_next
  import cpu_seq_pkg::*;
#(
  parameter int PC_W = cpu_seq_pkg::PC_W
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_target,
  input  pc_sel_t         i_sel,
  output logic [PC_W-1:0] o_pc_next
);
  always_comb o_pc_next = (i_sel == PC_TGT) ? i_target : (i_sel == PC_INC) ? i_pc + PC_W'(1) : i_pc;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC
// and sharing one memory port between instruction fetch and data access.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                PC_W     = cpu_seq_pkg::PC_W,
  parameter int                INSTR_W  = cpu_seq_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = cpu_seq_pkg::RESET_PC,
  parameter int                CNT_W    = cpu_seq_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_is_jump,
  input  logic               dec_is_branch,
  input  logic               dec_is_halt,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    j_instr_addr,
  input  logic [PC_W-1:0]    data_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_addr,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] ir,
  output logic [INSTR_W-1:0] mdr,
  output logic               reg_we,
  output logic               halted,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);
  state_t             r_state, w_next;
  pc_sel_t            w_sel;
  logic               w_retire;
  logic [PC_W-1:0]    r_pc, w_pc_next;
  logic [INSTR_W-1:0] r_ir, r_mdr;
  logic [CNT_W-1:0]   r_retired;

  seq_pc_next #(.PC_W(PC_W)) u_pc_next (
    .i_pc      (r_pc),
    .i_target  (j_instr_addr),
    .i_sel     (w_sel),
    .o_pc_next (w_pc_next)
  );

  // A store wins when both load and store flags are set
  always_comb begin
    w_next = r_state;
    w_sel = PC_HOLD;
    w_retire = 1'b0;
    case (r_state)
      IDLE:   w_next = run ? FETCH : IDLE;
      FETCH:  w_next = mem_ack ? DECODE : FETCH;
      DECODE: w_next = EXEC;
      EXEC: begin
        if (dec_is_halt) w_next = HALT;
        else if (dec_is_jump || dec_is_branch) begin
          w_retire = 1'b1;
          w_sel = (dec_is_jump || branch_taken) ? PC_TGT : PC_INC;
        end else w_next = (dec_is_load || dec_is_store) ? MEM : WB;
      end
      MEM: begin
        if (mem_ack && dec_is_store) begin
          w_retire = 1'b1;
          w_sel = PC_INC;
        end else if (mem_ack) w_next = WB;
      end
      WB: begin
        w_retire = 1'b1;
        w_sel = PC_INC;
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
    if (w_retire) w_next = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_mdr <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_pc <= w_pc_next;
      if (r_state == FETCH && mem_ack) r_ir <= mem_rdata;
      if (r_state == MEM && mem_ack && !dec_is_store) r_mdr <= mem_rdata;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Memory outputs decode from state so reset drops the request immediately
  assign mem_req  = (r_state == FETCH) || (r_state == MEM);
  assign mem_we   = (r_state == MEM) && dec_is_store;
  assign mem_addr = (r_state == MEM) ? data_addr : r_pc;
  assign PC       = r_pc;
  assign ir       = r_ir;
  assign mdr      = r_mdr;
  assign reg_we   = (r_state == WB);
  assign halted   = (r_state == HALT);
  assign state    = r_state;
  assign retired  = r_retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scenarios plus a random program checked against
// an instruction-level reference model (op in ir[31:29], address in ir[14:0]).
module tb_cpu_sequencer;
  logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic        dec_is_load, dec_is_store, dec_is_jump, dec_is_branch, dec_is_halt, branch_taken;
  logic [14:0] j_instr_addr, data_addr, mem_addr, PC;
  logic        mem_ack, mem_req, mem_we, reg_we, halted;
  logic [31:0] mem_rdata, ir, mdr;
  logic [2:0]  state, w_op;
  logic [15:0] retired;

  int checks = 0, fails = 0;
  logic [31:0] mem [0:32767];
  logic auto_mem = 1'b1, man_ack = 1'b0, a_ack = 1'b0, busy = 1'b0;
  logic [31:0] a_rdata = '0;
  int fetch_wait = 0, data_wait = 0, cnt = 0, rwe_cnt = 0;
  logic [14:0] st_q[$];

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
    .dec_is_branch(dec_is_branch), .dec_is_halt(dec_is_halt), .branch_taken(branch_taken),
    .j_instr_addr(j_instr_addr), .data_addr(data_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .PC(PC), .ir(ir), .mdr(mdr),
    .reg_we(reg_we), .halted(halted), .state(state), .retired(retired)
  );

  // Control-unit stand-in: 0/7 ALU, 1 load, 2 store, 3 jump, 4 branch, 5 halt, 6 load+store
  assign w_op          = ir[31:29];
  assign dec_is_load   = (w_op == 3'd1) || (w_op == 3'd6);
  assign dec_is_store  = (w_op == 3'd2) || (w_op == 3'd6);
  assign dec_is_jump   = (w_op == 3'd3);
  assign dec_is_branch = (w_op == 3'd4);
  assign dec_is_halt   = (w_op == 3'd5);
  assign branch_taken  = ir[28];
  assign j_instr_addr  = ir[14:0];
  assign data_addr     = ir[14:0];
  assign mem_ack       = auto_mem ? a_ack : man_ack;
  assign mem_rdata     = auto_mem ? a_rdata : 32'hDEAD_BEEF;

  // Memory model: a negative wait picks a random latency of 0..3 cycles
  always @(negedge clk) begin
    if (reg_we) rwe_cnt++;
    a_ack = 1'b0;
    if (auto_mem && mem_req && !reset) begin
      if (!busy) begin
        busy = 1'b1;
        cnt = (state == 3'd4) ? data_wait : fetch_wait;
        if (cnt < 0) cnt = int'($urandom_range(0, 3));
      end
      if (cnt == 0) begin
        a_ack = 1'b1;
        a_rdata = mem[mem_addr];
        busy = 1'b0;
        if (mem_we) st_q.push_back(mem_addr);
      end else cnt--;
    end else busy = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; fetch_wait = 0; data_wait = 0;
    repeat (2) step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (PC !== 15'd0) begin fails++; $display("FAIL rst_pc got=%h exp=0", PC); end
    checks++; if (ir !== 32'd0 || mdr !== 32'd0) begin fails++; $display("FAIL rst_ir_mdr got=%h/%h exp=0/0", ir, mdr); end
    checks++; if (retired !== 16'd0) begin fails++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    checks++; if ({mem_req, mem_we, reg_we, halted} !== 4'b0) begin fails++; $display("FAIL rst_ctrl got=%b exp=0000", {mem_req, mem_we, reg_we, halted}); end
    checks++; if (mem_addr !== 15'd0) begin fails++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    reset = 1'b0;
    repeat (3) step();
    checks++; if (state !== 3'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL idle_hold got state=%0d req=%b exp=0/0", state, mem_req); end
  endtask

  task automatic test_alu();
    mem[0] = {3'd0, 29'h0ABCDE};
    run = 1'b1;
    step();
    checks++; if (state !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 15'd0) begin fails++; $display("FAIL alu_fetch got=%0d/%b/%h exp=1/1/0", state, mem_req, mem_addr); end
    step();
    checks++; if (state !== 3'd2 || ir !== mem[0]) begin fails++; $display("FAIL alu_decode got=%0d/%h exp=2/%h", state, ir, mem[0]); end
    step();
    checks++; if (state !== 3'd3 || mem_req !== 1'b0) begin fails++; $display("FAIL alu_exec got=%0d/%b exp=3/0", state, mem_req); end
    step();
    checks++; if (state !== 3'd5 || reg_we !== 1'b1) begin fails++; $display("FAIL alu_wb got=%0d/%b exp=5/1", state, reg_we); end
    step();
    checks++; if (state !== 3'd1 || reg_we !== 1'b0 || PC !== 15'd1 || retired !== 16'd1) begin fails++; $display("FAIL alu_done got=%0d/%b/%h/%0d exp=1/0/1/1", state, reg_we, PC, retired); end
  endtask

  task automatic test_load();
    int n;
    logic ok;
    for (int i = 1; i < 4; i++) mem[i] = {3'd7, 29'h0};
    mem[4] = {3'd1, 14'h0, 15'h0100};
    mem[15'h0100] = $urandom;
    data_wait = 3;
    for (int k = 0; k < 60 && state !== 3'd4; k++) step();
    checks++; if (PC !== 15'd4 || state !== 3'd4) begin fails++; $display("FAIL load_reach got pc=%h state=%0d exp=4/4", PC, state); end
    n = 0; ok = 1'b1;
    while (state === 3'd4 && n < 20) begin
      if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 15'h0100)) ok = 1'b0;
      n++;
      step();
    end
    checks++; if (n != 4 || !ok) begin fails++; $display("FAIL load_hold got cycles=%0d stable=%b exp=4/1", n, ok); end
    checks++; if (state !== 3'd5 || reg_we !== 1'b1 || mdr !== mem[15'h0100]) begin fails++; $display("FAIL load_wb got=%0d/%b/%h exp=5/1/%h", state, reg_we, mdr, mem[15'h0100]); end
    step();
    checks++; if (PC !== 15'd5 || retired !== 16'd5 || reg_we !== 1'b0) begin fails++; $display("FAIL load_done got=%h/%0d/%b exp=5/5/0", PC, retired, reg_we); end
    data_wait = 0;
  endtask

  task automatic test_jump_branch();
    mem[5] = {3'd3, 14'h0, 15'h1234};
    mem[15'h1234] = {3'd3, 14'h0, 15'h7FFF};
    mem[15'h7FFF] = {3'd4, 1'b0, 13'h0, 15'h0055};
    for (int k = 0; k < 40 && retired !== 16'd6; k++) step();
    checks++; if (PC !== 15'h1234 || state !== 3'd1 || mem_addr !== 15'h1234) begin fails++; $display("FAIL jump got=%h/%0d/%h exp=1234/1/1234", PC, state, mem_addr); end
    for (int k = 0; k < 40 && retired !== 16'd7; k++) step();
    checks++; if (PC !== 15'h7FFF) begin fails++; $display("FAIL jump2 got=%h exp=7fff", PC); end
    for (int k = 0; k < 40 && retired !== 16'd8; k++) step();
    checks++; if (PC !== 15'd0) begin fails++; $display("FAIL branch_wrap got=%h exp=0", PC); end
  endtask

  task automatic test_store_run_drop();
    int n;
    logic ok;
    mem[0] = {3'd2, 14'h0, 15'h0200};
    data_wait = 3;
    st_q.delete();
    for (int k = 0; k < 40 && state !== 3'd4; k++) step();
    run = 1'b0;
    n = 0; ok = 1'b1;
    while (state === 3'd4 && n < 20) begin
      if (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 15'h0200)) ok = 1'b0;
      n++;
      step();
    end
    checks++; if (n != 4 || !ok) begin fails++; $display("FAIL store_hold got cycles=%0d stable=%b exp=4/1", n, ok); end
    checks++; if (state !== 3'd0 || mem_req !== 1'b0 || PC !== 15'd1 || retired !== 16'd9) begin fails++; $display("FAIL store_done got=%0d/%b/%h/%0d exp=0/0/1/9", state, mem_req, PC, retired); end
    checks++; if (st_q.size() != 1 || st_q[0] !== 15'h0200) begin fails++; $display("FAIL store_write got n=%0d exp one write to 0200", st_q.size()); end
    repeat (3) step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL store_idle got=%0d exp=0", state); end
    data_wait = 0;
  endtask

  task automatic test_halt();
    logic ok;
    mem[1] = {3'd5, 29'h1FFF_FFFF};
    run = 1'b1;
    for (int k = 0; k < 20 && halted !== 1'b1; k++) step();
    checks++; if (halted !== 1'b1 || state !== 3'd6 || PC !== 15'd1 || retired !== 16'd9 || mem_req !== 1'b0) begin fails++; $display("FAIL halt got=%b/%0d/%h/%0d/%b exp=1/6/1/9/0", halted, state, PC, retired, mem_req); end
    auto_mem = 1'b0; ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run = 1'($urandom); man_ack = 1'($urandom);
      step();
      if (halted !== 1'b1 || mem_req !== 1'b0 || PC !== 15'd1 || retired !== 16'd9) ok = 1'b0;
    end
    man_ack = 1'b0; run = 1'b1;
    checks++; if (!ok) begin fails++; $display("FAIL halt_stuck got left halt or changed state exp=stay halted"); end
    @(posedge clk); #3 reset = 1'b1; #1;
    checks++; if (halted !== 1'b0 || state !== 3'd0 || PC !== 15'd0) begin fails++; $display("FAIL halt_reset got=%b/%0d/%h exp=0/0/0", halted, state, PC); end
    auto_mem = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    fetch_wait = 10; run = 1'b1; reset = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd1 || mem_req !== 1'b1) begin fails++; $display("FAIL mid_fetch got=%0d/%b exp=1/1", state, mem_req); end
    step();
    #1 reset = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || state !== 3'd0 || PC !== 15'd0) begin fails++; $display("FAIL mid_reset got=%b/%0d/%h exp=0/0/0", mem_req, state, PC); end
    step();
    run = 1'b0; reset = 1'b0; auto_mem = 1'b0; man_ack = 1'b1;
    repeat (3) step();
    man_ack = 1'b0;
    checks++; if (state !== 3'd0 || ir !== 32'd0 || retired !== 16'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL stray_ack got=%0d/%h/%0d/%b exp=0/0/0/0", state, ir, retired, mem_req); end
    auto_mem = 1'b1; fetch_wait = 0;
  endtask

  task automatic test_random();
    logic [14:0] pc_m, exp_pc, tgt;
    logic [15:0] ret_m;
    logic [31:0] instr;
    logic [2:0] op;
    int rwe0, q0, exp_we;
    logic is_ld, is_st;
    reset = 1'b1; run = 1'b0;
    step();
    reset = 1'b0;
    fetch_wait = -1; data_wait = -1;
    for (int i = 0; i < 32768; i++) begin
      instr = $urandom;
      if (instr[31:29] == 3'd5) instr[31:29] = 3'd0;
      mem[i] = instr;
    end
    st_q.delete();
    pc_m = '0; ret_m = '0;
    for (int i = 0; i < 60; i++) begin
      instr = mem[pc_m]; op = instr[31:29]; tgt = instr[14:0];
      is_ld = (op == 3'd1);
      is_st = (op == 3'd2) || (op == 3'd6);
      exp_we = (op == 3'd0 || op == 3'd7 || is_ld) ? 1 : 0;
      exp_pc = (op == 3'd3 || (op == 3'd4 && instr[28])) ? tgt : pc_m + 15'd1;
      rwe0 = rwe_cnt; q0 = st_q.size();
      for (int k = 0; k < 200 && retired === ret_m; k++) begin
        run = ($urandom_range(0, 3) != 0);
        step();
      end
      ret_m = ret_m + 16'd1;
      checks++; if (retired !== ret_m || PC !== exp_pc) begin fails++; $display("FAIL rnd_retire i=%0d op=%0d got=%0d/%h exp=%0d/%h", i, op, retired, PC, ret_m, exp_pc); end
      checks++; if (rwe_cnt - rwe0 != exp_we) begin fails++; $display("FAIL rnd_regwe i=%0d got=%0d exp=%0d", i, rwe_cnt - rwe0, exp_we); end
      if (is_ld) begin
        checks++; if (mdr !== mem[tgt]) begin fails++; $display("FAIL rnd_mdr i=%0d got=%h exp=%h", i, mdr, mem[tgt]); end
      end
      checks++; if (st_q.size() != q0 + (is_st ? 1 : 0) || (is_st && st_q[$] !== tgt)) begin fails++; $display("FAIL rnd_store i=%0d got n=%0d exp n=%0d addr=%h", i, st_q.size() - q0, is_st ? 1 : 0, tgt); end
      pc_m = exp_pc;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_jump_branch();
    test_store_run_drop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
